// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor, WIDTH bits in 4-bit groups.
// Ports: clk, rst, in_valid/in_ready, a, b, cin, sub, out_valid/out_ready, sum, cout, ovf, blk_g, blk_p.
module pipelined_cla_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             blk_g,
    output logic             blk_p
);

    localparam int GROUPS = WIDTH / 4;

    if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
        $error("pipelined_cla_adder: WIDTH must be a multiple of 4 in 4..64");
    end

    // Handshake
    logic w_s2_move;
    logic w_s1_move;
    logic w_accept;
    logic r_s1_valid;
    logic r_s2_valid;

    assign w_s2_move = ~r_s2_valid | out_ready;
    assign w_s1_move = ~r_s1_valid | w_s2_move;
    assign w_accept  = in_valid & w_s1_move;
    assign in_ready  = w_s1_move;
    assign out_valid = r_s2_valid;

    // Operand conditioning
    logic [WIDTH-1:0]  w_beff;
    logic [WIDTH-1:0]  w_g;
    logic [WIDTH-1:0]  w_p;
    logic              w_c0;
    logic [GROUPS-1:0] w_gg;
    logic [GROUPS-1:0] w_gp;

    assign w_beff = sub ? ~b : b;
    assign w_c0   = cin ^ sub;
    assign w_g    = a & w_beff;
    assign w_p    = a ^ w_beff;

    for (genvar k = 0; k < GROUPS; k++) begin : g_grp
        assign w_gg[k] = w_g[4*k+3]
                       | (w_p[4*k+3] & w_g[4*k+2])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
        assign w_gp[k] = &w_p[4*k+3:4*k];
    end

    // Stage 1 registers
    logic [WIDTH-1:0]  r_s1_p;
    logic [WIDTH-1:0]  r_s1_g;
    logic [GROUPS-1:0] r_s1_gg;
    logic [GROUPS-1:0] r_s1_gp;
    logic              r_s1_c0;
    logic              r_s1_amsb;
    logic              r_s1_bmsb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_p     <= '0;
            r_s1_g     <= '0;
            r_s1_gg    <= '0;
            r_s1_gp    <= '0;
            r_s1_c0    <= 1'b0;
            r_s1_amsb  <= 1'b0;
            r_s1_bmsb  <= 1'b0;
        end else begin
            if (w_s1_move) begin
                r_s1_valid <= w_accept;
            end
            if (w_accept) begin
                r_s1_p    <= w_p;
                r_s1_g    <= w_g;
                r_s1_gg   <= w_gg;
                r_s1_gp   <= w_gp;
                r_s1_c0   <= w_c0;
                r_s1_amsb <= a[WIDTH-1];
                r_s1_bmsb <= w_beff[WIDTH-1];
            end
        end
    end

    // Second lookahead level: each carry is a flat sum of products of
    // group G/P terms, then the in-group carries expand from C_k.
    logic [GROUPS:0]  w_gc;
    logic [WIDTH-1:0] w_c;
    logic             w_blk_g;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;

    always_comb begin
        logic prod;
        logic cy;
        prod    = 1'b1;
        cy      = 1'b0;
        w_blk_g = 1'b0;
        w_gc    = '0;
        w_c     = '0;
        w_gc[0] = r_s1_c0;
        for (int k = 0; k < GROUPS; k++) begin
            prod = 1'b1;
            cy   = 1'b0;
            for (int j = k; j >= 0; j--) begin
                cy   = cy | (prod & r_s1_gg[j]);
                prod = prod & r_s1_gp[j];
            end
            w_gc[k+1] = cy | (prod & r_s1_c0);
            if (k == GROUPS - 1) begin
                w_blk_g = cy;
            end
        end
        for (int i = 0; i < WIDTH; i++) begin
            prod = 1'b1;
            cy   = 1'b0;
            for (int j = i - 1; j >= (i / 4) * 4; j--) begin
                cy   = cy | (prod & r_s1_g[j]);
                prod = prod & r_s1_p[j];
            end
            w_c[i] = cy | (prod & w_gc[i/4]);
        end
    end

    assign w_sum = r_s1_p ^ w_c;
    // Same-sign operands with a result of the other sign; equals c[MSB]^cout.
    assign w_ovf = (r_s1_amsb ~^ r_s1_bmsb) & (r_s1_amsb ^ w_sum[WIDTH-1]);

    // Stage 2 registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            sum        <= '0;
            cout       <= 1'b0;
            ovf        <= 1'b0;
            blk_g      <= 1'b0;
            blk_p      <= 1'b0;
        end else if (w_s2_move) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                sum   <= w_sum;
                cout  <= w_gc[GROUPS];
                ovf   <= w_ovf;
                blk_g <= w_blk_g;
                blk_p <= &r_s1_gp;
            end
        end
    end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, two-stage pipelined carry-lookahead adder/subtractor; the successor to the fixed 4-bit lookahead unit.
- Operands are split into 4-bit lookahead groups; group generate/propagate values are combined by a second lookahead level.
- Valid/ready handshakes on input and output let it sit directly in the ALU datapath with backpressure.
- Exports word-level generate/propagate so several instances can be chained by a higher-level lookahead unit.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and in the range 4..64. Any other value is a synthesis-time error.
- GROUPS, WIDTH/4, number of 4-bit lookahead groups; derived, not overridable.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and mode present this cycle.
- in_ready  output  1  block accepts an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-in (sub).
- sub  input  1  0 = A+B+cin; 1 = A-B-cin.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out of the MSB; in sub mode 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.
- blk_g  output  1  word-level generate.
- blk_p  output  1  word-level propagate.

Behaviour:
- Reset (async, rst=1): s1_valid=0, s2_valid=0, out_valid=0, sum=0, cout=0, ovf=0, blk_g=0, blk_p=0. in_ready=1 for the whole time rst is asserted and on the first cycle after release.
- Operand conditioning:
  - b_eff = sub ? ~b : b.
  - c0 = cin ^ sub, so sub with cin=0 gives A+~B+1.
  - Per-bit g[i] = a[i] & b_eff[i]; p[i] = a[i] ^ b_eff[i].
- Stage 1 (registered on accept):
  - Capture p[WIDTH-1:0], g[WIDTH-1:0] and c0.
  - Capture each group's G_k and P_k using standard 4-bit lookahead equations.
  - Capture a[MSB] and b_eff[MSB] for overflow.
- Stage 2 (registered on advance):
  - Group carries: C_0 = c0; C_{k+1} = G_k | (P_k & C_k), computed in lookahead (flattened) form, not ripple.
  - In-group carries use 4-bit lookahead from C_k.
  - sum[i] = p[i] ^ c[i]; cout = C_GROUPS.
  - ovf = c[WIDTH-1] ^ cout.
  - blk_g = word-level generate; blk_p = AND of all P_k. Neither depends on c0.
- Handshake:
  - Accept when in_valid & in_ready.
  - s2_move = ~s2_valid | out_ready.
  - s1_move = ~s1_valid | s2_move.
  - in_ready = s1_move. This is a combinational path from out_ready and is permitted.
  - Stage 1 loads on accept. s1_valid is set by accept and cleared when stage 1 drains into stage 2 with no new accept.
  - Stage 2 loads when s1_valid & s2_move. out_valid = s2_valid.
- Latency and throughput:
  - Latency is exactly 2 cycles: accept at edge N gives out_valid=1 after edge N+1.
  - Throughput is one operation per cycle when out_ready=1.
- Stall: while out_valid & ~out_ready, sum, cout, ovf, blk_g and blk_p stay stable. Stage 1 holds one more operation, then in_ready drops to 0.
- Simultaneous events: with a full pipe and out_ready=1, output retire, stage 1→2 transfer and a new accept all happen on the same edge with no bubble.
- Invalid cycles: inputs with in_valid=0 are ignored. Register contents may update when the corresponding valid is 0, but outputs are only meaningful when out_valid=1.
- Reset mid-operation: in-flight operations are discarded, no partial result appears, and outputs return to their reset values immediately.
- Ordering: results leave strictly in acceptance order; no operation is dropped or duplicated.

Test Plan:
- WIDTH=16, add, a=0xFFFF, b=0x0001, cin=0 -> two cycles later sum=0x0000, cout=1, ovf=0, blk_p=0, blk_g=1.
- Add, a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
- Sub tests:
  - a=0x0005, b=0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0.
  - a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
  - a=0x0005, b=0x0003, cin=1 -> sum=0x0001, cout=1.
- Propagate chain: add, a=0xAAAA, b=0x5555, cin=1 -> sum=0x0000, cout=1, blk_p=1, blk_g=0; with cin=0 -> sum=0xFFFF, cout=0.
- Backpressure: stream 5 ops back-to-back, hold out_ready=0 for 4 cycles from the first out_valid.
  - in_ready falls after 2 ops are in flight and the output stays stable.
  - After release, all 5 results arrive in order, one per cycle.
- Reset and parameters:
  - Assert rst with 2 ops in flight -> out_valid=0 immediately and all outputs 0; post-reset op a=0x0003, b=0x0004 -> sum=0x0007 after 2 cycles.
  - Repeat random add/sub (compared against a behavioural model) for WIDTH=4, 32 and 64.
